// File: rtl/issue_ctrl.sv
// Issue/sequencing controller for the MPU datapath: accepts decoded instructions,
// holds one instruction in EX for ALU_LAT cycles, stalls on RAW hazards, drains on halt.
module issue_ctrl #(
   parameter int ALU_LAT = 1,
   parameter int STALL_W = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [4:0]         in_rs1,
   input  logic [4:0]         in_rs2,
   input  logic [4:0]         in_rd,
   input  logic               in_we,
   input  logic [2:0]         in_op,
   input  logic               halt_req,
   output logic               halted,
   output logic [4:0]         rf_r1_addr,
   output logic [4:0]         rf_r2_addr,
   output logic               alubuf1_load,
   output logic               alubuf2_load,
   output logic [2:0]         alu_op,
   output logic [4:0]         rf_rw_addr,
   output logic               rf_write,
   output logic [31:0]        retired,
   output logic [STALL_W-1:0] stall_cnt
);

   localparam logic [1:0] LAST_CNT = 2'(ALU_LAT - 1);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t               r_state;
   logic                 r_ex_valid;
   logic                 r_ex_we;
   logic [4:0]           r_ex_rd;
   logic [2:0]           r_ex_op;
   logic [1:0]           r_ex_cnt;
   logic [31:0]          r_retired;
   logic [STALL_W-1:0]   r_stall_cnt;

   logic                 w_ex_last;
   logic                 w_hazard;
   logic                 w_in_ready;
   logic                 w_accept;
   logic                 w_stall;

   // Valid/ready: an instruction transfers in any cycle where in_valid and in_ready
   // are both high; in_valid may drop without a transfer and nothing is held before it.
   assign w_ex_last  = r_ex_valid && (r_ex_cnt == LAST_CNT);
   // No forwarding: a match even on the producer's last EX cycle must wait for the write.
   assign w_hazard   = r_ex_valid && r_ex_we && (r_ex_rd != 5'd0) &&
                       ((in_rs1 == r_ex_rd) || (in_rs2 == r_ex_rd));
   assign w_in_ready = (r_state == RUN) && !halt_req && !reset &&
                       (!r_ex_valid || w_ex_last) && !w_hazard;
   assign w_accept   = in_valid && w_in_ready;
   assign w_stall    = in_valid && !w_in_ready && (r_state == RUN) && !halt_req;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= RUN;
         r_ex_valid  <= 1'b0;
         r_ex_we     <= 1'b0;
         r_ex_rd     <= 5'd0;
         r_ex_op     <= 3'd0;
         r_ex_cnt    <= 2'd0;
         r_retired   <= 32'd0;
         r_stall_cnt <= '0;
      end else begin
         case (r_state)
            RUN:     if (halt_req && !r_ex_valid) r_state <= HALTED;
            HALTED:  if (!halt_req) r_state <= RUN;
            default: r_state <= RUN;
         endcase

         if (w_accept) begin
            r_ex_valid <= 1'b1;
            r_ex_rd    <= in_rd;
            r_ex_we    <= in_we;
            r_ex_op    <= in_op;
            r_ex_cnt   <= 2'd0;
         end else if (w_ex_last) begin
            r_ex_valid <= 1'b0;
         end else if (r_ex_valid) begin
            r_ex_cnt   <= r_ex_cnt + 2'd1;
         end

         if (w_ex_last) r_retired <= r_retired + 32'd1;

         if (w_stall && (r_stall_cnt != {STALL_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign in_ready     = w_in_ready;
   assign halted       = (r_state == HALTED);
   assign rf_r1_addr   = in_rs1;
   assign rf_r2_addr   = in_rs2;
   // Operand buffers capture regfile outputs only at accept, so they stay put through EX.
   assign alubuf1_load = w_accept;
   assign alubuf2_load = w_accept;
   assign alu_op       = r_ex_op;
   assign rf_rw_addr   = r_ex_rd;
   assign rf_write     = w_ex_last && r_ex_we && (r_ex_rd != 5'd0);
   assign retired      = r_retired;
   assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: one instance with ALU_LAT=1 (suffix _a) and one with ALU_LAT=3 (suffix _b).
module tb_issue_ctrl;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic [15:0] cyc = 16'd0;
   always @(posedge clock) cyc <= cyc + 16'd1;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- DUT A (ALU_LAT=1) ----------------
   logic        reset_a, in_valid_a, in_ready_a, in_we_a, halt_a, halted_a;
   logic [4:0]  in_rs1_a, in_rs2_a, in_rd_a, r1_a, r2_a, rf_rw_addr_a;
   logic [2:0]  in_op_a, alu_op_a;
   logic        load1_a, load2_a, rf_write_a;
   logic [31:0] retired_a;
   logic [15:0] stall_a;

   issue_ctrl #(.ALU_LAT(1), .STALL_W(16)) u_dut_a (
      .clock(clock), .reset(reset_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_rs1(in_rs1_a), .in_rs2(in_rs2_a), .in_rd(in_rd_a), .in_we(in_we_a), .in_op(in_op_a),
      .halt_req(halt_a), .halted(halted_a), .rf_r1_addr(r1_a), .rf_r2_addr(r2_a),
      .alubuf1_load(load1_a), .alubuf2_load(load2_a), .alu_op(alu_op_a),
      .rf_rw_addr(rf_rw_addr_a), .rf_write(rf_write_a), .retired(retired_a), .stall_cnt(stall_a)
   );

   // ---------------- DUT B (ALU_LAT=3) ----------------
   logic        reset_b, in_valid_b, in_ready_b, in_we_b, halt_b, halted_b;
   logic [4:0]  in_rs1_b, in_rs2_b, in_rd_b, r1_b, r2_b, rf_rw_addr_b;
   logic [2:0]  in_op_b, alu_op_b;
   logic        load1_b, load2_b, rf_write_b;
   logic [31:0] retired_b;
   logic [15:0] stall_b;

   issue_ctrl #(.ALU_LAT(3), .STALL_W(16)) u_dut_b (
      .clock(clock), .reset(reset_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_rs1(in_rs1_b), .in_rs2(in_rs2_b), .in_rd(in_rd_b), .in_we(in_we_b), .in_op(in_op_b),
      .halt_req(halt_b), .halted(halted_b), .rf_r1_addr(r1_b), .rf_r2_addr(r2_b),
      .alubuf1_load(load1_b), .alubuf2_load(load2_b), .alu_op(alu_op_b),
      .rf_rw_addr(rf_rw_addr_b), .rf_write(rf_write_b), .retired(retired_b), .stall_cnt(stall_b)
   );

   // Scoreboard entries: {expected write cycle[15:0], rd[4:0], op[2:0]}
   logic [23:0] exp_q_a[$];
   logic [23:0] exp_q_b[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic nxt();
      @(posedge clock);
      #1;
   endtask

   task automatic smp();
      @(negedge clock);
   endtask

   task automatic drv_a(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we, input logic [2:0] op);
      in_valid_a = v; in_rs1_a = rs1; in_rs2_a = rs2; in_rd_a = rd; in_we_a = we; in_op_a = op;
   endtask

   task automatic drv_b(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we, input logic [2:0] op);
      in_valid_b = v; in_rs1_b = rs1; in_rs2_b = rs2; in_rd_b = rd; in_we_b = we; in_op_b = op;
   endtask

   // Expected writes are queued when a transfer is seen and retired when rf_write fires.
   always @(negedge clock) begin
      logic [23:0] e;
      if (reset_a) exp_q_a.delete();
      else begin
         if (in_valid_a && in_ready_a && in_we_a && (in_rd_a != 5'd0))
            exp_q_a.push_back({cyc + 16'd1, in_rd_a, in_op_a});
         if (rf_write_a) begin
            if (exp_q_a.size() == 0) check("a_unexpected_write", 32'(rf_rw_addr_a), 32'hffff_ffff);
            else begin
               e = exp_q_a.pop_front();
               check("a_wr_cycle", 32'(cyc), 32'(e[23:8]));
               check("a_wr_addr", 32'(rf_rw_addr_a), 32'(e[7:3]));
               check("a_wr_op", 32'(alu_op_a), 32'(e[2:0]));
            end
         end
      end
   end

   always @(negedge clock) begin
      logic [23:0] e;
      if (reset_b) exp_q_b.delete();
      else begin
         if (in_valid_b && in_ready_b && in_we_b && (in_rd_b != 5'd0))
            exp_q_b.push_back({cyc + 16'd3, in_rd_b, in_op_b});
         if (rf_write_b) begin
            if (exp_q_b.size() == 0) check("b_unexpected_write", 32'(rf_rw_addr_b), 32'hffff_ffff);
            else begin
               e = exp_q_b.pop_front();
               check("b_wr_cycle", 32'(cyc), 32'(e[23:8]));
               check("b_wr_addr", 32'(rf_rw_addr_b), 32'(e[7:3]));
               check("b_wr_op", 32'(alu_op_b), 32'(e[2:0]));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   logic [4:0] t3_rs1[4] = '{5'd1, 5'd0, 5'd1, 5'd5};
   logic [4:0] t3_rs2[4] = '{5'd2, 5'd0, 5'd2, 5'd5};
   logic [4:0] t3_rd [4] = '{5'd0, 5'd0, 5'd5, 5'd0};
   logic       t3_we [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      logic [2:0] op0, op1;
      reset_a = 1'b1; reset_b = 1'b1; halt_a = 1'b0; halt_b = 1'b0;
      drv_a(0, 0, 0, 0, 0, 0);
      drv_b(0, 0, 0, 0, 0, 0);

      // reset state
      smp();
      check("rst_ready_a", 32'(in_ready_a), 0);
      check("rst_halted_a", 32'(halted_a), 0);
      check("rst_write_a", 32'(rf_write_a), 0);
      check("rst_load_a", 32'(load1_a), 0);
      check("rst_retired_a", retired_a, 0);
      check("rst_stall_a", 32'(stall_a), 0);
      check("rst_ready_b", 32'(in_ready_b), 0);
      check("rst_aluop_b", 32'(alu_op_b), 0);
      check("rst_rwaddr_b", 32'(rf_rw_addr_b), 0);
      nxt();
      reset_a = 1'b0; reset_b = 1'b0;

      // four independent instructions back to back, ALU_LAT=1
      for (int i = 0; i < 4; i++) begin
         drv_a(1, 5'd1, 5'd2, 5'(3 + i), 1, 3'($urandom_range(0, 7)));
         smp();
         check("t1_ready", 32'(in_ready_a), 1);
         check("t1_load", 32'(load1_a & load2_a), 1);
         nxt();
      end
      drv_a(0, 0, 0, 0, 0, 0);
      smp();
      check("t1_last_write", 32'(rf_write_a), 1);
      check("t1_last_addr", 32'(rf_rw_addr_a), 6);
      nxt(); smp();
      check("t1_retired", retired_a, 4);
      check("t1_stall", 32'(stall_a), 0);
      check("t1_idle_write", 32'(rf_write_a), 0);

      // RAW hazard: x3 = x1+x2 ; x4 = x3+x1
      nxt();
      drv_a(1, 5'd1, 5'd2, 5'd3, 1, 3'd0);
      smp();
      check("t2_prod_ready", 32'(in_ready_a), 1);
      nxt();
      drv_a(1, 5'd3, 5'd1, 5'd4, 1, 3'd1);
      smp();
      check("t2_stall_ready", 32'(in_ready_a), 0);
      check("t2_prod_write", 32'(rf_write_a), 1);
      nxt(); smp();
      check("t2_cons_ready", 32'(in_ready_a), 1);
      nxt();
      drv_a(0, 0, 0, 0, 0, 0);
      smp();
      check("t2_cons_write", 32'(rf_write_a), 1);
      nxt(); smp();
      check("t2_retired", retired_a, 6);
      check("t2_stall", 32'(stall_a), 1);

      // producers writing x0 or not writing at all never stall a consumer
      nxt();
      for (int i = 0; i < 4; i++) begin
         drv_a(1, t3_rs1[i], t3_rs2[i], t3_rd[i], t3_we[i], 3'($urandom_range(0, 7)));
         smp();
         check("t3_ready", 32'(in_ready_a), 1);
         check("t3_no_write", 32'(rf_write_a), 0);
         nxt();
      end
      drv_a(0, 0, 0, 0, 0, 0);
      smp();
      check("t3_no_write_tail", 32'(rf_write_a), 0);
      nxt(); smp();
      check("t3_retired", retired_a, 10);
      check("t3_stall", 32'(stall_a), 1);

      // ALU_LAT=3, two independent instructions back to back
      nxt();
      op0 = 3'($urandom_range(0, 7));
      drv_b(1, 5'd1, 5'd2, 5'd3, 1, op0);
      smp();
      check("t4_ready0", 32'(in_ready_b), 1);
      check("t4_load0", 32'(load1_b & load2_b), 1);
      nxt();
      op1 = 3'($urandom_range(0, 7));
      drv_b(1, 5'd1, 5'd2, 5'd4, 1, op1);
      for (int k = 1; k <= 2; k++) begin
         smp();
         check("t4_busy_ready", 32'(in_ready_b), 0);
         check("t4_busy_load", 32'(load1_b | load2_b), 0);
         check("t4_busy_op", 32'(alu_op_b), 32'(op0));
         check("t4_busy_write", 32'(rf_write_b), 0);
         nxt();
      end
      smp();
      check("t4_ready1", 32'(in_ready_b), 1);
      check("t4_load1", 32'(load1_b & load2_b), 1);
      check("t4_write0", 32'(rf_write_b), 1);
      check("t4_addr0", 32'(rf_rw_addr_b), 3);
      nxt();
      drv_b(0, 0, 0, 0, 0, 0);
      for (int k = 4; k <= 5; k++) begin
         smp();
         check("t4_op1", 32'(alu_op_b), 32'(op1));
         check("t4_idle_load", 32'(load1_b | load2_b), 0);
         check("t4_idle_write", 32'(rf_write_b), 0);
         nxt();
      end
      smp();
      check("t4_write1", 32'(rf_write_b), 1);
      check("t4_addr1", 32'(rf_rw_addr_b), 4);
      nxt(); smp();
      check("t4_retired", retired_b, 2);
      check("t4_stall", 32'(stall_b), 2);

      // halt during EX: drain, halt, resume
      nxt();
      drv_b(1, 5'd1, 5'd2, 5'd5, 1, 3'($urandom_range(0, 7)));
      smp();
      check("t5_ready0", 32'(in_ready_b), 1);
      nxt();
      drv_b(1, 5'd1, 5'd2, 5'd6, 1, 3'($urandom_range(0, 7)));
      halt_b = 1'b1;
      smp(); check("t5_ready_n1", 32'(in_ready_b), 0);
      nxt(); smp(); check("t5_ready_n2", 32'(in_ready_b), 0);
      nxt(); smp();
      check("t5_ready_n3", 32'(in_ready_b), 0);
      check("t5_drain_write", 32'(rf_write_b), 1);
      check("t5_drain_addr", 32'(rf_rw_addr_b), 5);
      nxt(); smp();
      check("t5_halted_n4", 32'(halted_b), 0);
      check("t5_ready_n4", 32'(in_ready_b), 0);
      nxt(); smp();
      check("t5_halted_n5", 32'(halted_b), 1);
      check("t5_ready_n5", 32'(in_ready_b), 0);
      check("t5_stall_n5", 32'(stall_b), 2);
      nxt();
      halt_b = 1'b0;
      smp();
      check("t5_halted_n6", 32'(halted_b), 1);
      check("t5_ready_n6", 32'(in_ready_b), 0);
      nxt(); smp();
      check("t5_halted_n7", 32'(halted_b), 0);
      check("t5_resume_ready", 32'(in_ready_b), 1);
      check("t5_resume_load", 32'(load1_b), 1);
      nxt();
      drv_b(0, 0, 0, 0, 0, 0);
      smp(); nxt(); smp(); nxt(); smp();
      check("t5_resume_write", 32'(rf_write_b), 1);
      check("t5_resume_addr", 32'(rf_rw_addr_b), 6);
      nxt(); smp();
      check("t5_retired", retired_b, 4);
      check("t5_stall", 32'(stall_b), 2);

      // reset in EX cycle 2 discards the instruction
      nxt();
      drv_b(1, 5'd1, 5'd2, 5'd7, 1, 3'd7);
      smp();
      check("t6_ready0", 32'(in_ready_b), 1);
      nxt();
      drv_b(0, 0, 0, 0, 0, 0);
      smp(); nxt();
      reset_b = 1'b1;
      #1;
      check("t6_rst_ready", 32'(in_ready_b), 0);
      check("t6_rst_write", 32'(rf_write_b), 0);
      check("t6_rst_retired", retired_b, 0);
      check("t6_rst_stall", 32'(stall_b), 0);
      check("t6_rst_aluop", 32'(alu_op_b), 0);
      check("t6_rst_rwaddr", 32'(rf_rw_addr_b), 0);
      check("t6_rst_halted", 32'(halted_b), 0);
      smp();
      nxt();
      reset_b = 1'b0;
      drv_b(1, 5'd1, 5'd2, 5'd8, 1, 3'($urandom_range(0, 7)));
      smp();
      check("t6_post_ready", 32'(in_ready_b), 1);
      nxt();
      drv_b(0, 0, 0, 0, 0, 0);
      smp(); nxt(); smp(); nxt(); smp();
      check("t6_post_write", 32'(rf_write_b), 1);
      check("t6_post_addr", 32'(rf_rw_addr_b), 8);
      nxt(); smp();
      check("t6_post_retired", retired_b, 1);

      // every queued write must have been seen
      nxt(); smp();
      check("sb_empty_a", 32'(exp_q_a.size()), 0);
      check("sb_empty_b", 32'(exp_q_b.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
